// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - CLINT register offsets, reset values and address decode
package clint_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI
  } reg_sel_e;

  // Decodes a word address (byte offset with the two LSBs dropped).
  function automatic reg_sel_e decode_addr(input logic [13:0] word_addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (word_addr == MSIP_OFF[15:2])        sel = SEL_MSIP;
    if (word_addr == MTIMECMP_LO_OFF[15:2]) sel = SEL_CMP_LO;
    if (word_addr == MTIMECMP_HI_OFF[15:2]) sel = SEL_CMP_HI;
    if (word_addr == MTIME_LO_OFF[15:2])    sel = SEL_TIME_LO;
    if (word_addr == MTIME_HI_OFF[15:2])    sel = SEL_TIME_HI;
    return sel;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// rtl/clint_prescaler.sv - free-running divider producing one tick per PRESCALE cycles
module clint_prescaler #(
  parameter int unsigned PRESCALE = 10
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] r_count;

  assign tick = (r_count == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= 16'd0;
    end else if (tick) begin
      r_count <= 16'd0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

endmodule

// File: rtl/clint.sv
// rtl/clint.sv - core-local interruptor: msip, 64-bit mtime/mtimecmp, single-outstanding bus
module clint
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 10,
  parameter int unsigned RESP_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [15:0] io_req_addr,
  input  logic        io_req_wen,
  input  logic [31:0] io_req_wdata,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [31:0] io_resp_rdata,
  output logic        io_mtip,
  output logic        io_msip
);

  if (RESP_LAT != 1) begin : g_bad_resp_lat
    $error("clint: only RESP_LAT = 1 is supported");
  end

  logic        w_tick;
  logic        w_accept;
  reg_sel_e    w_sel;
  logic [31:0] w_rdata;
  logic [63:0] w_mtime_inc;
  logic        w_unused_addr_lsb;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_mtip;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;

  clint_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_unused_addr_lsb = ^io_req_addr[1:0];

  assign io_req_ready  = !r_resp_valid || io_resp_ready;
  assign w_accept      = io_req_valid && io_req_ready;
  assign w_sel         = decode_addr(io_req_addr[15:2]);
  assign w_mtime_inc   = r_mtime + 64'(w_tick);

  assign io_resp_valid = r_resp_valid;
  assign io_resp_rdata = r_resp_rdata;
  assign io_mtip       = r_mtip;
  assign io_msip       = r_msip;

  // Read mux sees pre-write, pre-tick state of the accepting cycle.
  always_comb begin
    w_rdata = 32'd0;
    case (w_sel)
      SEL_MSIP:    w_rdata = {31'd0, r_msip};
      SEL_CMP_LO:  w_rdata = r_mtimecmp[31:0];
      SEL_CMP_HI:  w_rdata = r_mtimecmp[63:32];
      SEL_TIME_LO: w_rdata = r_mtime[31:0];
      SEL_TIME_HI: w_rdata = r_mtime[63:32];
      default:     w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mtime      <= 64'd0;
      r_mtimecmp   <= MTIMECMP_RST;
      r_msip       <= 1'b0;
      r_mtip       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_mtime <= w_mtime_inc;
      r_mtip  <= (r_mtime >= r_mtimecmp);

      if (w_accept) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= io_req_wen ? 32'd0 : w_rdata;
        if (io_req_wen) begin
          // A write to one mtime half keeps the other half's ticked value.
          case (w_sel)
            SEL_MSIP:    r_msip             <= io_req_wdata[0];
            SEL_CMP_LO:  r_mtimecmp[31:0]   <= io_req_wdata;
            SEL_CMP_HI:  r_mtimecmp[63:32]  <= io_req_wdata;
            SEL_TIME_LO: r_mtime            <= {w_mtime_inc[63:32], io_req_wdata};
            SEL_TIME_HI: r_mtime            <= {io_req_wdata, w_mtime_inc[31:0]};
            default:     ;
          endcase
        end
      end else if (io_resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 Parameter PRESCALE, default 10: number of clock cycles per mtime tick; legal range 1..65535.
REQ-002 Parameter RESP_LAT, default 1: cycles from request acceptance to response; fixed at 1 in this revision.
REQ-003 clock  input  1  single clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_req_valid  input  1  bus request present.
REQ-006 io_req_ready  output  1  block accepts the request this cycle.
REQ-007 io_req_addr  input  16  byte offset within the CLINT window; bits [1:0] are ignored.
REQ-008 io_req_wen  input  1  1 = write, 0 = read.
REQ-009 io_req_wdata  input  32  write data; full-word writes only.
REQ-010 io_resp_valid  output  1  response present.
REQ-011 io_resp_ready  input  1  consumer takes the response.
REQ-012 io_resp_rdata  output  32  read data; 0 for writes.
REQ-013 io_mtip  output  1  machine timer interrupt, to core io_interrupts_mtip.
REQ-014 io_msip  output  1  machine software interrupt, to core io_interrupts_msip.

Function
REQ-015 The register map SHALL be:
- 0x0000 msip (bit0, bits 31:1 read 0)
- 0x4000 mtimecmp[31:0]
- 0x4004 mtimecmp[63:32]
- 0xBFF8 mtime[31:0]
- 0xBFFC mtime[63:32]
REQ-016 Handshake: transfer on io_req_valid && io_req_ready; one request outstanding; io_req_ready = !io_resp_valid || io_resp_ready.
REQ-017 io_resp_valid SHALL assert the cycle after acceptance and hold, with stable rdata, until io_resp_ready is high.
REQ-018 Read data SHALL be sampled at acceptance: the pre-write and pre-tick value of that cycle.
REQ-019 Unmapped offsets: reads return 0; writes are ignored; a response is still produced.
REQ-020 Prescaler: counts 0..PRESCALE-1 and wraps; mtime increments by 1 on each wrap cycle (every cycle when PRESCALE = 1).
REQ-021 mtime is a 64-bit counter; the increment carries from lo to hi; 0xFFFFFFFF_FFFFFFFF wraps to 0.
REQ-022 A write to mtime lo or hi in a tick cycle: the written half takes the write data, the other half takes its incremented value (write wins).
REQ-023 Writes to mtime do not reset the prescaler.
REQ-024 io_mtip SHALL be registered as (mtime >= mtimecmp), unsigned 64-bit compare, one cycle after the operands change.
REQ-025 io_msip SHALL equal the msip register bit, effective the cycle after the write is accepted.
REQ-026 Reset mid-transaction SHALL drop any pending response; no write completes after reset asserts.

Reset
REQ-027 On reset: mtime = 0, prescaler = 0, mtimecmp = 0xFFFFFFFF_FFFFFFFF, msip = 0, io_mtip = 0, io_msip = 0, io_resp_valid = 0, io_resp_rdata = 0, io_req_ready = 1 the cycle after reset deasserts.

Structure
REQ-028 Package clint_pkg SHALL hold the address-offset constants (MSIP_OFF, MTIMECMP_LO/HI_OFF, MTIME_LO/HI_OFF) and the reset value of mtimecmp.
REQ-029 The prescaler SHALL be a sub-module clint_prescaler (parameter PRESCALE; output tick).

Verification
REQ-030 Reset release, PRESCALE = 10, no bus traffic, 200 cycles -> mtime = 20; io_mtip = 0; io_msip = 0.
REQ-031 Write mtimecmp = 5 (hi = 0 first, then lo = 5) -> io_mtip rises exactly one cycle after mtime reaches 5.
REQ-032 Write mtime lo = 0xFFFFFFFF, hi = 0 -> after the next tick, reading hi returns 1 and reading lo returns 0.
REQ-033 Write msip = 1 -> io_msip = 1 next cycle; write 0 -> io_msip = 0; a read of 0x0000 returns 1 in between.
REQ-034 Hold io_resp_ready = 0 for 3 cycles after a read of 0xBFF8 -> io_req_ready = 0, rdata stable, new requests stall.
REQ-035 Read of 0x1234 -> rdata 0; assert reset while a response is pending -> io_resp_valid = 0 the next cycle.
